// File: rtl/uart_tx_ser.sv
// uart_tx_ser: byte-to-serial UART transmitter.
// The input side has a one-deep holding register, so the next byte can be queued
// while the current frame shifts out.
// It sends 8N1 frames by default.
// Define UART_TX_PARITY_EN to compile in an even-parity bit, which gives 8E1 frames.
// STOP_BITS selects 1 or 2 stop bits.
module uart_tx_ser #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned BAUD      = 115_200,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       gclk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       uart_tx_out,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int unsigned BaudW        = $clog2(CLKS_PER_BIT);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
      StParity = 3'd3,
`endif
      StStop   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             line_q, line_d;
   logic             baud_tick;
   logic             load;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign baud_tick   = (baud_q == BaudLast);
   assign tx_ready    = !hold_full_q && rst_n;
   assign busy        = (state_q != StIdle) || hold_full_q;
   assign uart_tx_out = line_q;

   // Next-state logic: frame sequencing, holding register, and the registered line value
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_tick ? '0 : baud_q + 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      line_d      = line_q;
      load        = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      unique case (state_q)
         StIdle: begin
            baud_d = '0;
            if (hold_full_q) load = 1'b1;
         end
         StStart: begin
            if (baud_tick) begin
               state_d = StData;
               bit_d   = '0;
            end
         end
         StData: begin
            if (baud_tick) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
                  bit_d = '0;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_tick) begin
               state_d = StStop;
               bit_d   = '0;
            end
         end
`endif
         StStop: begin
            if (baud_tick) begin
               if (bit_q == StopLast) begin
                  // A queued byte starts its frame on this same edge, so no idle gap appears.
                  if (hold_full_q) load = 1'b1;
                  else             state_d = StIdle;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         state_d     = StStart;
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         bit_d       = '0;
         baud_d      = '0;
`ifdef UART_TX_PARITY_EN
         parity_d    = ^hold_q;
`endif
      end

      // tx_ready is low while a byte is held, so an accept and a load never coincide.
      if (tx_valid && tx_ready) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      // The line value is derived from the next state, so the output can be registered.
      case (state_d)
         StStart:  line_d = 1'b0;
         StData:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: line_d = parity_d;
`endif
         default:  line_d = 1'b1;
      endcase
   end

   // State register with synchronous active-low reset; reset drives the line to idle high
   always_ff @(posedge gclk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         line_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         line_q      <= line_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_ser.sv
// tb_uart_tx_ser: directed bench for uart_tx_ser.
// Instance u_dut_a uses the defaults (868 clocks per bit, 1 stop bit).
// Instance u_dut_b is set to STOP_BITS = 2.
// Frames are checked on the first and last cycle of every bit.
// The bench picks up UART_TX_PARITY_EN when the macro is defined.
module tb_uart_tx_ser;

   localparam int N = 868;
`ifdef UART_TX_PARITY_EN
   localparam int P      = 1;
   localparam int FrameA = 9548;
   localparam int FrameB = 10416;
`else
   localparam int P      = 0;
   localparam int FrameA = 8680;
   localparam int FrameB = 9548;
`endif

   logic       gclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] tx_data = 8'h00;

   logic valid_a, valid_b, ready_a, ready_b, line_a, line_b, busy_a, busy_b;
   logic ready_m, line_m, busy_m;

   assign valid_a = tx_valid & ~sel;
   assign valid_b = tx_valid & sel;
   assign ready_m = sel ? ready_b : ready_a;
   assign line_m  = sel ? line_b : line_a;
   assign busy_m  = sel ? busy_b : busy_a;

   uart_tx_ser u_dut_a (
      .gclk        (gclk),
      .rst_n       (rst_n),
      .tx_data     (tx_data),
      .tx_valid    (valid_a),
      .tx_ready    (ready_a),
      .uart_tx_out (line_a),
      .busy        (busy_a)
   );

   uart_tx_ser #(.STOP_BITS(2)) u_dut_b (
      .gclk        (gclk),
      .rst_n       (rst_n),
      .tx_data     (tx_data),
      .tx_valid    (valid_b),
      .tx_ready    (ready_b),
      .uart_tx_out (line_b),
      .busy        (busy_b)
   );

   always #5 gclk = ~gclk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cyc[$];
   logic [7:0] acc_dat[$];
   int start_cyc[$];

   always @(posedge gclk) cyc <= cyc + 1;

   // Log handshakes 1 ns before the edge that completes them, tagged with the post-edge count
   always @(negedge gclk) begin
      #4;
      if (tx_valid && ready_m) begin
         acc_cyc.push_back(cyc + 1);
         acc_dat.push_back(tx_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge gclk);
   endtask

   // Offer a byte and keep tx_valid high; returns on the negedge after the accepting edge
   task automatic push(input logic [7:0] b);
      int n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (ready_m !== 1'b1 && n < 4 * FrameB) begin
         @(negedge gclk);
         n++;
      end
      check("push_ready", ready_m, 1);
      @(negedge gclk);
   endtask

   task automatic wait_start();
      int n = 0;
      while (line_m !== 1'b0 && n < 4 * FrameB) begin
         @(negedge gclk);
         n++;
      end
      check("start_seen", line_m, 0);
   endtask

   // Called in the first cycle of a start bit; returns in the first cycle after the frame
   task automatic expect_frame(input logic [7:0] b, input int nstop);
      logic [11:0] bits;
      int nb;
      nb        = 9 + P + nstop;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      if (P == 1) bits[9] = ^b;
      start_cyc.push_back(cyc);
      for (int i = 0; i < nb; i++) begin
         check($sformatf("b%02h_bit%0d_first", b, i), line_m, bits[i]);
         tick(N - 1);
         check($sformatf("b%02h_bit%0d_last", b, i), line_m, bits[i]);
         if (i == nb - 1) check($sformatf("b%02h_busy_end", b), busy_m, 1);
         tick(1);
      end
   endtask

   task automatic clear_logs();
      acc_cyc.delete();
      acc_dat.delete();
      start_cyc.delete();
   endtask

   initial begin
      #1_200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(3);
      check("rst_ready", ready_a, 0);
      check("rst_line_a", line_a, 1);
      check("rst_line_b", line_b, 1);
      check("rst_busy", busy_a, 0);
      rst_n = 1'b1;
      #1;
      check("release_ready", ready_a, 1);
      check("release_busy", busy_a, 0);
      clear_logs();

      // Single byte 0x55
      push(8'h55);
      check("held_ready_low", ready_m, 0);
      check("held_line_idle", line_m, 1);
      check("held_busy", busy_m, 1);
      tx_valid = 1'b0;
      tick(1);
      expect_frame(8'h55, 1);
      check("single_idle_busy", busy_m, 0);
      check("single_idle_line", line_m, 1);
      check("single_idle_ready", ready_m, 1);
      check("single_latency", start_cyc[0] - acc_cyc[0], 1);
      clear_logs();

      // Back-to-back plus backpressure: A5, 3C, 96 with tx_valid held high
      fork
         begin
            push(8'hA5);
            push(8'h3C);
            push(8'h96);
            tx_valid = 1'b0;
         end
         begin
            wait_start();
            expect_frame(8'hA5, 1);
            expect_frame(8'h3C, 1);
            expect_frame(8'h96, 1);
         end
      join
      check("b2b_accepts", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3 && start_cyc.size() == 3) begin
         check("b2b_dat0", acc_dat[0], 8'hA5);
         check("b2b_dat1", acc_dat[1], 8'h3C);
         check("b2b_dat2", acc_dat[2], 8'h96);
         check("b2b_acc1_in_start", acc_cyc[1] - start_cyc[0], 1);
         check("b2b_acc2_after_load", acc_cyc[2] - start_cyc[1], 1);
         check("b2b_gap01", start_cyc[1] - start_cyc[0], FrameA);
         check("b2b_gap12", start_cyc[2] - start_cyc[1], FrameA);
      end
      check("b2b_idle_busy", busy_m, 0);
      clear_logs();

      // Parity bytes (plain 8N1 frames when parity is not compiled in)
      fork
         begin
            push(8'h07);
            push(8'h03);
            tx_valid = 1'b0;
         end
         begin
            wait_start();
            expect_frame(8'h07, 1);
            expect_frame(8'h03, 1);
         end
      join
      if (start_cyc.size() == 2) check("par_frame_len", start_cyc[1] - start_cyc[0], FrameA);
      check("par_idle_busy", busy_m, 0);
      clear_logs();

      // Reset mid-frame during DATA bit 3 of 0xF0 (bit 3 is a 0, so the line is low)
      push(8'hF0);
      tx_valid = 1'b0;
      wait_start();
      tick(4 * N + N / 2);
      check("mid_bit3_low", line_m, 0);
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_line", line_m, 1);
      check("mid_rst_busy", busy_m, 0);
      check("mid_rst_ready", ready_m, 0);
      tick(2);
      rst_n = 1'b1;
      tick(N);
      check("post_rst_line", line_m, 1);
      check("post_rst_busy", busy_m, 0);
      push(8'h3C);
      tx_valid = 1'b0;
      tick(1);
      expect_frame(8'h3C, 1);
      check("post_rst_idle", busy_m, 0);
      clear_logs();

      // Two stop bits on the second instance
      sel = 1'b1;
      tick(1);
      push(8'hFF);
      tx_valid = 1'b0;
      tick(1);
      expect_frame(8'hFF, 2);
      check("stop2_line", line_m, 1);
      check("stop2_busy", busy_m, 0);
      check("stop2_ready", ready_m, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
